// File: rtl/cpu_checker_stream_arbiter_if.sv
// rtl/cpu_checker_stream_arbiter_if.sv - two-source character streams into cpu_checker plus grant status
interface cpu_checker_stream_arbiter_if;
  logic [7:0] src0_char;
  logic       src0_valid;
  logic       src0_ready;
  logic [7:0] src1_char;
  logic       src1_valid;
  logic       src1_ready;
  logic [7:0] out_char;
  logic [1:0] out_owner;
  logic [7:0] abort_cnt;

  modport master (
    output src0_char, src0_valid, src1_char, src1_valid,
    input  src0_ready, src1_ready, out_char, out_owner, abort_cnt
  );

  modport slave (
    input  src0_char, src0_valid, src1_char, src1_valid,
    output src0_ready, src1_ready, out_char, out_owner, abort_cnt
  );
endinterface

// File: rtl/cpu_checker_stream_arbiter.sv
// rtl/cpu_checker_stream_arbiter.sv - record-atomic round-robin arbiter feeding cpu_checker's character input
module cpu_checker_stream_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu_checker_stream_arbiter_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] CHAR_HASH = 8'h23;
  localparam logic [7:0] CHAR_SPC  = 8'h20;
  localparam logic [7:0] CHAR_NUL  = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] out_char_q, out_char_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       last_q, last_d;

  logic       grant_src;
  logic       grant_valid;
  logic [7:0] grant_char;
  logic [7:0] idle_inc;

  assign grant_src   = (state_q == GRANT1);
  assign grant_valid = grant_src ? bus.src1_valid : bus.src0_valid;
  assign grant_char  = grant_src ? bus.src1_char  : bus.src0_char;
  assign idle_inc    = idle_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_char_q  <= CHAR_NUL;
      abort_cnt_q <= 8'd0;
      idle_cnt_q  <= 8'd0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_char_q  <= out_char_d;
      abort_cnt_q <= abort_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_char_d  = CHAR_NUL;
    abort_cnt_d = abort_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        idle_cnt_d = 8'd0;
        if (bus.src0_valid && bus.src1_valid) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (bus.src0_valid) begin
          state_d = GRANT0;
        end else if (bus.src1_valid) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        if (grant_valid) begin
          out_char_d = grant_char;
          idle_cnt_d = 8'd0;
          if (grant_char == CHAR_HASH) begin
            last_d  = grant_src;
            state_d = IDLE;
          end
        end else begin
          idle_cnt_d = idle_inc;
          // Evicted source is recorded now so the other side wins the next tie.
          if (idle_inc == TIMEOUT_C) begin
            last_d  = grant_src;
            state_d = ABORT;
          end
        end
      end

      ABORT: begin
        out_char_d = CHAR_SPC;
        if (abort_cnt_q != 8'hFF) begin
          abort_cnt_d = abort_cnt_q + 8'd1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.src0_ready = (state_q == GRANT0);
  assign bus.src1_ready = (state_q == GRANT1);
  assign bus.out_owner  = (state_q == GRANT0) ? 2'b01 :
                          (state_q == GRANT1) ? 2'b10 : 2'b00;
  assign bus.out_char   = out_char_q;
  assign bus.abort_cnt  = abort_cnt_q;

endmodule

// File: tb/tb_cpu_checker_stream_arbiter.sv
// tb/tb_cpu_checker_stream_arbiter.sv - directed self-checking bench for cpu_checker_stream_arbiter
module tb_cpu_checker_stream_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_checker_stream_arbiter_if bus();

  cpu_checker_stream_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  string rec_a = "^33@00003333: $ 0 <= fffffb28#";
  string rec_b = "*33@00003334: *00000010 <= 0000abcd#";
  string part  = "^32@0000";

  logic       mon_en = 1'b0;
  logic [7:0] out_q[$];
  logic [1:0] own_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      out_q.push_back(bus.out_char);
      own_q.push_back(bus.out_owner);
    end
  end

  function automatic int first_nz();
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] != 8'h00) return i;
    return out_q.size();
  endfunction

  task automatic drive0(input string s, input int reps);
    int guard;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < s.len(); i++) begin
        bus.src0_char  = s[i];
        bus.src0_valid = 1'b1;
        guard = 0;
        while (bus.src0_ready !== 1'b1 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drive0_grant: src0_ready=%b required 1 within 200 cycles", bus.src0_ready);
          bus.src0_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    bus.src0_valid = 1'b0;
  endtask

  task automatic drive1(input string s, input int reps);
    int guard;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < s.len(); i++) begin
        bus.src1_char  = s[i];
        bus.src1_valid = 1'b1;
        guard = 0;
        while (bus.src1_ready !== 1'b1 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drive1_grant: src1_ready=%b required 1 within 200 cycles", bus.src1_ready);
          bus.src1_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    bus.src1_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.src0_char = 8'h00; bus.src0_valid = 1'b0;
    bus.src1_char = 8'h00; bus.src1_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_char !== 8'h00) begin n_bad++; $display("FAIL reset_out_char: got %h required 00", bus.out_char); end
    n_cmp++; if (bus.src0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_src0_ready: got %b required 0", bus.src0_ready); end
    n_cmp++; if (bus.src1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_src1_ready: got %b required 0", bus.src1_ready); end
    n_cmp++; if (bus.out_owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %b required 00", bus.out_owner); end
    n_cmp++; if (bus.abort_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_abort_cnt: got %0d required 0", bus.abort_cnt); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_owner !== 2'b00) begin n_bad++; $display("FAIL idle_no_valid_owner: got %b required 00", bus.out_owner); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    logic [1:0] eo;
    bus.src0_char  = rec_a[0];
    bus.src0_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.src0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_latency: got %b required 1", bus.src0_ready); end
    n_cmp++; if (bus.out_owner !== 2'b01) begin n_bad++; $display("FAIL single_owner_grant: got %b required 01", bus.out_owner); end
    n_cmp++; if (bus.out_char !== 8'h00) begin n_bad++; $display("FAIL single_pre_char: got %h required 00", bus.out_char); end
    for (int i = 0; i < rec_a.len(); i++) begin
      @(negedge clk);
      if (i + 1 < rec_a.len()) bus.src0_char = rec_a[i+1];
      else bus.src0_valid = 1'b0;
      e  = rec_a[i];
      eo = (i == rec_a.len() - 1) ? 2'b00 : 2'b01;
      n_cmp++; if (bus.out_char !== e) begin n_bad++; $display("FAIL single_char[%0d]: got %h required %h", i, bus.out_char, e); end
      n_cmp++; if (bus.out_owner !== eo) begin n_bad++; $display("FAIL single_owner[%0d]: got %b required %b", i, bus.out_owner, eo); end
    end
    @(negedge clk);
    n_cmp++; if (bus.out_char !== 8'h00) begin n_bad++; $display("FAIL single_post_char: got %h required 00", bus.out_char); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_q[$];
    int k;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    out_q.delete(); own_q.delete();
    mon_en = 1'b1;
    fork
      drive0(rec_a, 1);
      drive1(rec_b, 1);
    join
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    for (int i = 0; i < rec_a.len(); i++) exp_q.push_back(rec_a[i]);
    exp_q.push_back(8'h00);
    for (int i = 0; i < rec_b.len(); i++) exp_q.push_back(rec_b[i]);
    k = first_nz();
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (k + j >= out_q.size()) begin
        n_bad++; $display("FAIL contention_len[%0d]: stream ended, required %h", j, exp_q[j]);
        break;
      end else if (out_q[k+j] !== exp_q[j]) begin
        n_bad++; $display("FAIL contention_char[%0d]: got %h required %h", j, out_q[k+j], exp_q[j]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [1:0] seq[$];
    logic [1:0] prev;
    logic [1:0] eo;
    out_q.delete(); own_q.delete();
    mon_en = 1'b1;
    fork
      drive0(rec_a, 4);
      drive1(rec_b, 4);
    join
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    prev = 2'b00;
    foreach (own_q[i]) begin
      if (own_q[i] != 2'b00 && own_q[i] != prev) seq.push_back(own_q[i]);
      prev = own_q[i];
    end
    n_cmp++; if (seq.size() != 8) begin n_bad++; $display("FAIL fairness_grants: got %0d required 8", seq.size()); end
    for (int k = 0; k < 8 && k < seq.size(); k++) begin
      eo = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (seq[k] !== eo) begin n_bad++; $display("FAIL fairness_owner[%0d]: got %b required %b", k, seq[k], eo); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_q[$];
    int k;
    out_q.delete(); own_q.delete();
    mon_en = 1'b1;
    fork
      drive1(part, 1);
      begin
        repeat (2) @(negedge clk);
        drive0(rec_a, 1);
      end
    join
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    for (int i = 0; i < part.len(); i++) exp_q.push_back(part[i]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h00);
    for (int i = 0; i < rec_a.len(); i++) exp_q.push_back(rec_a[i]);
    k = first_nz();
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (k + j >= out_q.size()) begin
        n_bad++; $display("FAIL timeout_len[%0d]: stream ended, required %h", j, exp_q[j]);
        break;
      end else if (out_q[k+j] !== exp_q[j]) begin
        n_bad++; $display("FAIL timeout_char[%0d]: got %h required %h", j, out_q[k+j], exp_q[j]);
      end
    end
    n_cmp++; if (bus.abort_cnt !== 8'd1) begin n_bad++; $display("FAIL timeout_abort_cnt: got %0d required 1", bus.abort_cnt); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 256; n++) begin
      bus.src0_char  = 8'h5e;
      bus.src0_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.src0_valid = 1'b0;
      repeat (6) @(negedge clk);
      if (n == 0) begin
        n_cmp++; if (bus.abort_cnt !== 8'd2) begin n_bad++; $display("FAIL sat_first: got %0d required 2", bus.abort_cnt); end
      end
      if (n == 253) begin
        n_cmp++; if (bus.abort_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d required 255", bus.abort_cnt); end
      end
    end
    n_cmp++; if (bus.abort_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d required 255", bus.abort_cnt); end
  endtask

  task automatic test_reset_mid();
    bus.src0_char  = 8'h61;
    bus.src0_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.out_owner !== 2'b01) begin n_bad++; $display("FAIL mid_owner: got %b required 01", bus.out_owner); end
    n_cmp++; if (bus.out_char !== 8'h61) begin n_bad++; $display("FAIL mid_char: got %h required 61", bus.out_char); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.out_char !== 8'h00) begin n_bad++; $display("FAIL async_out_char: got %h required 00", bus.out_char); end
    n_cmp++; if (bus.src0_ready !== 1'b0) begin n_bad++; $display("FAIL async_src0_ready: got %b required 0", bus.src0_ready); end
    n_cmp++; if (bus.out_owner !== 2'b00) begin n_bad++; $display("FAIL async_owner: got %b required 00", bus.out_owner); end
    n_cmp++; if (bus.abort_cnt !== 8'd0) begin n_bad++; $display("FAIL async_abort_cnt: got %0d required 0", bus.abort_cnt); end
    bus.src1_char  = 8'h2a;
    bus.src1_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_owner !== 2'b00) begin n_bad++; $display("FAIL held_reset_owner: got %b required 00", bus.out_owner); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_owner !== 2'b01) begin n_bad++; $display("FAIL post_reset_tie: got %b required 01", bus.out_owner); end
    n_cmp++; if (bus.src1_ready !== 1'b0) begin n_bad++; $display("FAIL post_reset_src1_ready: got %b required 0", bus.src1_ready); end
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
